// File: rtl/morph_filter_3x3.sv
// 3x3 grayscale morphology stage (erode/dilate/bypass) with two RAM line buffers, border masking and self-flush.
// Build option MORPH_BINARISE_EN adds iTHRESH and binarises each accepted pixel before the line buffers.
module morph_filter_3x3 #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [DATA_W-1:0] iDATA,
  input  logic [1:0]        iMODE,
`ifdef MORPH_BINARISE_EN
  input  logic [DATA_W-1:0] iTHRESH,
`endif
  output logic              oBUSY,
  output logic              oDVAL,
  output logic [DATA_W-1:0] oDATA,
  output logic              oSOF,
  output logic              oOVF
);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned FW = $clog2(IMG_W + 1);
  localparam logic [1:0] M_ERODE  = 2'b01;
  localparam logic [1:0] M_DILATE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

  state_t            state_q, next_state;
  logic              busy_q, ovf_q;
  logic [1:0]        mode_q;
  logic [CW-1:0]     col_q, ctr_c_q;
  logic [RW-1:0]     row_q, ctr_r_q;
  logic [FW-1:0]     flush_q;

  logic              accept, sof_acc, advance, produce;
  logic [CW-1:0]     addr;
  logic [DATA_W-1:0] pix_data, pix_in;

  logic [DATA_W-1:0] lb0_mem [IMG_W];
  logic [DATA_W-1:0] lb1_mem [IMG_W];
  logic [DATA_W-1:0] lb0_rd_q, lb1_rd_q;

  logic              s1_adv_q, s1_vld_q, s1_sof_q;
  logic [CW-1:0]     s1_addr_q, s1_c_q;
  logic [RW-1:0]     s1_r_q;
  logic [1:0]        s1_mode_q;
  logic [DATA_W-1:0] s1_pix_q;

  logic              s2_vld_q, s2_sof_q;
  logic [CW-1:0]     s2_c_q;
  logic [RW-1:0]     s2_r_q;
  logic [1:0]        s2_mode_q;
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] tap   [3][3];
  logic [DATA_W-1:0] nval;

  logic              s3_vld_q, s3_sof_q;
  logic [1:0]        s3_mode_q;
  logic [DATA_W-1:0] s3_col_q [3];
  logic [DATA_W-1:0] s3_ctr_q;

  function automatic logic [DATA_W-1:0] pick(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic use_max);
    if (use_max) return (a > b) ? a : b;
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] red3(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c,
                                             input logic use_max);
    return pick(pick(a, b, use_max), c, use_max);
  endfunction

  // Pixel written to the line buffers: live data, or neutral filler for flush cycles
  always_comb begin
`ifdef MORPH_BINARISE_EN
    pix_data = (iDATA >= iTHRESH) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
`else
    pix_data = iDATA;
`endif
    pix_in = (state_q == S_FLUSH) ? ((mode_q == M_ERODE) ? {DATA_W{1'b1}} : {DATA_W{1'b0}})
                                  : pix_data;
  end

  always_comb begin
    next_state = state_q;
    accept     = iDVAL && !busy_q;
    sof_acc    = accept && iSOF;
    advance    = 1'b0;
    produce    = 1'b0;
    addr       = col_q;
    case (state_q)
      S_IDLE: begin
        if (sof_acc) begin
          next_state = S_FILL;
          advance    = 1'b1;
          addr       = '0;
        end
      end
      S_FILL, S_RUN: begin
        if (sof_acc) begin
          next_state = S_FILL;
          advance    = 1'b1;
          addr       = '0;
        end else if (accept) begin
          advance = 1'b1;
          if (state_q == S_FILL) begin
            if (row_q == RW'(1) && col_q == CW'(1)) begin
              next_state = S_RUN;
              produce    = 1'b1;
            end
          end else begin
            produce = 1'b1;
            if (row_q == RW'(IMG_H - 1) && col_q == CW'(IMG_W - 1)) next_state = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        advance = 1'b1;
        produce = 1'b1;
        if (flush_q == FW'(IMG_W)) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      mode_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      ctr_c_q <= '0;
      ctr_r_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= next_state;
      busy_q  <= (next_state == S_FLUSH);
      flush_q <= (state_q == S_FLUSH) ? flush_q + FW'(1) : '0;
      if ((iDVAL && busy_q) || (sof_acc && (state_q == S_FILL || state_q == S_RUN))) ovf_q <= 1'b1;
      if (sof_acc) mode_q <= iMODE;
      if (advance) col_q <= (addr == CW'(IMG_W - 1)) ? '0 : addr + CW'(1);
      if (sof_acc) row_q <= '0;
      else if (advance && state_q != S_FLUSH && addr == CW'(IMG_W - 1)) row_q <= row_q + RW'(1);
      // Centre position of the next output, stepped once per produced output
      if (sof_acc) begin
        ctr_c_q <= '0;
        ctr_r_q <= '0;
      end else if (produce) begin
        if (ctr_c_q == CW'(IMG_W - 1)) begin
          ctr_c_q <= '0;
          ctr_r_q <= ctr_r_q + RW'(1);
        end else begin
          ctr_c_q <= ctr_c_q + CW'(1);
        end
      end
    end
  end

  // Line buffers: synchronous read-before-write; line 1 is refilled from line 0 one cycle later
  always_ff @(posedge CLOCK) begin
    if (advance) begin
      lb0_rd_q      <= lb0_mem[addr];
      lb1_rd_q      <= lb1_mem[addr];
      lb0_mem[addr] <= pix_in;
    end
    if (s1_adv_q) lb1_mem[s1_addr_q] <= lb0_rd_q;
  end

  always_comb begin
    nval = (s2_mode_q == M_ERODE) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 3; i++) begin
        tap[j][i] = win_q[j][i];
        if ((i == 0 && s2_r_q == '0) || (i == 2 && s2_r_q == RW'(IMG_H - 1)) ||
            (j == 0 && s2_c_q == '0) || (j == 2 && s2_c_q == CW'(IMG_W - 1)))
          tap[j][i] = nval;
      end
    end
  end

  // Pipeline: RAM read -> window shift -> masked column reduce -> final reduce
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      s1_adv_q  <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_sof_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_c_q    <= '0;
      s1_r_q    <= '0;
      s1_mode_q <= '0;
      s1_pix_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_sof_q  <= 1'b0;
      s2_c_q    <= '0;
      s2_r_q    <= '0;
      s2_mode_q <= '0;
      s3_vld_q  <= 1'b0;
      s3_sof_q  <= 1'b0;
      s3_mode_q <= '0;
      s3_ctr_q  <= '0;
      for (int j = 0; j < 3; j++) begin
        s3_col_q[j] <= '0;
        for (int i = 0; i < 3; i++) win_q[j][i] <= '0;
      end
      oDVAL <= 1'b0;
      oSOF  <= 1'b0;
      oDATA <= '0;
    end else begin
      s1_adv_q  <= advance;
      s1_vld_q  <= produce;
      s1_sof_q  <= produce && (state_q == S_FILL);
      s1_c_q    <= ctr_c_q;
      s1_r_q    <= ctr_r_q;
      s1_mode_q <= mode_q;
      if (advance) begin
        s1_addr_q <= addr;
        s1_pix_q  <= pix_in;
      end
      s2_vld_q  <= s1_vld_q;
      s2_sof_q  <= s1_sof_q;
      s2_c_q    <= s1_c_q;
      s2_r_q    <= s1_r_q;
      s2_mode_q <= s1_mode_q;
      if (s1_adv_q) begin
        for (int i = 0; i < 3; i++) begin
          win_q[0][i] <= win_q[1][i];
          win_q[1][i] <= win_q[2][i];
        end
        win_q[2][0] <= lb1_rd_q;
        win_q[2][1] <= lb0_rd_q;
        win_q[2][2] <= s1_pix_q;
      end
      s3_vld_q  <= s2_vld_q;
      s3_sof_q  <= s2_sof_q;
      s3_mode_q <= s2_mode_q;
      if (s2_vld_q) begin
        s3_ctr_q <= win_q[1][1];
        for (int j = 0; j < 3; j++)
          s3_col_q[j] <= red3(tap[j][0], tap[j][1], tap[j][2], s2_mode_q == M_DILATE);
      end
      oDVAL <= s3_vld_q;
      oSOF  <= s3_vld_q && s3_sof_q;
      if (s3_vld_q)
        oDATA <= (s3_mode_q == M_ERODE || s3_mode_q == M_DILATE)
                 ? red3(s3_col_q[0], s3_col_q[1], s3_col_q[2], s3_mode_q == M_DILATE)
                 : s3_ctr_q;
    end
  end

  assign oBUSY = busy_q;
  assign oOVF  = ovf_q;

endmodule

// File: doc/morph_filter_3x3.md
Name: morph_filter_3x3

Overview:
- Parametrised 3x3 grayscale morphology stage for the camera pixel pipeline. Sits between capture/colour conversion and downstream detection logic.
- Per-frame selectable mode: erode (min), dilate (max) or bypass.
- Holds its own line buffers and row/column counters, and masks image borders with a neutral value.
- After the last pixel of a frame it self-flushes, so every frame yields exactly IMG_W*IMG_H output pixels.

Parameters:
- DATA_W, 10, pixel width in bits.
- IMG_W, 640, pixels per line; must be >= 4.
- IMG_H, 480, lines per frame; must be >= 3.

Ports:
- CLOCK  in  1  single clock; all logic on rising edge.
- RESET_N  in  1  reset, synchronous, active-low.
- iDVAL  in  1  input pixel valid.
- iSOF  in  1  start of frame; qualified by iDVAL and marks pixel (0,0).
- iDATA  in  DATA_W  input pixel, raster order.
- iMODE  in  2  00 bypass, 01 erode, 10 dilate, 11 bypass.
- oBUSY  out  1  high during FLUSH; upstream must not assert iDVAL.
- oDVAL  out  1  output pixel valid.
- oDATA  out  DATA_W  filtered pixel.
- oSOF  out  1  high with oDVAL on output pixel (0,0).
- oOVF  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (RESET_N=0 at a clock edge):
  - oDVAL=0, oSOF=0, oBUSY=0, oOVF=0, oDATA=0.
  - FSM goes to IDLE; counters and window registers are cleared.
  - Line-buffer RAM contents are don't-care.
  - Reset mid-frame abandons the frame; no further outputs are produced for it.
- Accepting pixels: an input pixel is accepted when iDVAL=1 and oBUSY=0. The accept count n runs 0..IMG_W*IMG_H-1.
- FSM states:
  - IDLE: accepted pixels without iSOF are ignored. An accept with iSOF=1 latches iMODE into the frame mode, sets n=0 and moves to FILL.
  - FILL: entered at n=0. At the accept of n=IMG_W+1, move to RUN; that accept produces the first output. No outputs are produced before it.
  - RUN: each accept n produces output for centre index m = n-(IMG_W+1). When n reaches IMG_W*IMG_H-1, move to FLUSH.
  - FLUSH: oBUSY=1. Injects exactly IMG_W+1 virtual pixels, one per clock, each producing the next output. Then oBUSY=0 and the FSM returns to IDLE.
- Centre position: for centre index m, row r = m div IMG_W and column c = m mod IMG_W, tracked by counters (no divider).
- Window taps outside the image are replaced by a neutral value:
  - taps in row r-1 when r=0, row r+1 when r=IMG_H-1, column c-1 when c=0, column c+1 when c=IMG_W-1;
  - neutral value is all-ones for erode and 0 for dilate.
  - Virtual (flush) pixels are always masked.
- Arithmetic:
  - erode: oDATA = min of the 9 taps;
  - dilate: oDATA = max of the 9 taps;
  - bypass: oDATA = centre tap.
  - Unsigned compares, computed as a registered comparator tree.
- Latency:
  - oDVAL/oDATA for centre m appear exactly 3 clocks after the accept (or virtual-pixel cycle) that produced it. This latency is fixed in all modes.
  - oDVAL is high for one clock per output. Gaps in iDVAL propagate as gaps in oDVAL.
- oSOF is asserted with output m=0.
- Mode changes: iMODE changes mid-frame have no effect; the mode latched at SOF is used.
- iSOF with an accept in FILL or RUN: the current frame is aborted.
  - Outputs already in the 3-stage pipeline still emit; no further outputs for the old frame.
  - The pixel is taken as (0,0) of a new frame, iMODE is relatched, and the FSM goes to FILL.
  - oOVF is set.
- iDVAL=1 while oBUSY=1: the pixel is dropped (even with iSOF) and oOVF is set.
- RAM-based line buffers: 2 lines of IMG_W x DATA_W, addressed by the column counter, with read-before-write.

Optional Feature:
- MORPH_BINARISE_EN.
- Defined:
  - adds input port iTHRESH (DATA_W bits);
  - each accepted pixel is replaced before the line buffers by all-ones if iDATA >= iTHRESH, else 0;
  - iTHRESH is sampled per pixel;
  - result is binary erosion/dilation with unchanged latency.
- Undefined: no iTHRESH port; grayscale data passes straight to the line buffers.

Test Plan:
- IMG_W=8, IMG_H=6, mode dilate. Frame all 0 except (2,3)=1023, continuous iDVAL.
  - Expect 48 outputs; 1023 exactly at rows 1-3, cols 2-4, else 0.
  - oSOF on the first output, which arrives 3 clocks after accept of n=9.
  - oBUSY high for exactly 9 clocks after the last accept.
- Same sizes, mode erode. Frame all 1023 except (0,0)=100.
  - Expect 100 at (0,0), (0,1), (1,0), (1,1); 1023 elsewhere, borders included (no edge shrink).
- Mode bypass, ramp iDATA=n, iDVAL toggling 1/0 each clock.
  - Expect oDATA = 0..47 in order.
  - Each output exactly 3 clocks after the accept of n = m+9.
- Dilate frame with iDVAL held high during FLUSH.
  - Expect those pixels dropped and oOVF=1 until reset.
  - Still exactly 48 outputs for the frame.
- iSOF reasserted at n=20, then a full new frame in erode.
  - oOVF=1; no old-frame outputs beyond those already in the pipeline.
  - New frame yields 48 outputs with the erode result.
- RESET_N=0 for 1 clock mid-RUN.
  - Next clock: oDVAL=0, oBUSY=0, oOVF=0.
  - Pixels without iSOF are ignored until an iSOF accept.
